// File: rtl/char_overlay_if.sv
// char_overlay_if: bundles the text write port, the pixel stream in/out and the char_rom port.
// Latency: none; this is wiring only.
// Backpressure: none; the stream and the ROM port advance every clock.
// Modports: slave = overlay view (consumes pixels and writes, drives rom_addr and the output
//           stream); master = environment view (the opposite directions).
interface char_overlay_if #(
    parameter int AW = 6
);
    logic          text_we;
    logic [AW-1:0] text_waddr;
    logic [9:0]    text_wdata;
    logic [11:0]   pix_x;
    logic [11:0]   pix_y;
    logic          i_hs;
    logic          i_vs;
    logic          i_de;
    logic [23:0]   i_rgb;
    logic [9:0]    rom_addr;
    logic [143:0]  rom_data;
    logic          o_hs;
    logic          o_vs;
    logic          o_de;
    logic [23:0]   o_rgb;

    modport slave (
        input  text_we, text_waddr, text_wdata,
        input  pix_x, pix_y, i_hs, i_vs, i_de, i_rgb,
        input  rom_data,
        output rom_addr,
        output o_hs, o_vs, o_de, o_rgb
    );

    modport master (
        output text_we, text_waddr, text_wdata,
        output pix_x, pix_y, i_hs, i_vs, i_de, i_rgb,
        output rom_data,
        input  rom_addr,
        input  o_hs, o_vs, o_de, o_rgb
    );
endinterface

// File: rtl/char_overlay.sv
// char_overlay: paints glyphs from a COLS x ROWS text buffer over a pixel stream in FG_COLOR.
// Latency: fixed 4 clocks pixel-in to pixel-out (syncs/de/rgb matched); rom_addr leads rom_data by 1.
// Backpressure: none; one pixel per clock, text writes are accepted on any clock.
// Ports: clk, rst (asynchronous, active high); bus (char_overlay_if.slave) with the text write
//        port, input stream pix_x/pix_y/i_*, char_rom rom_addr/rom_data and output stream o_*.
// Option: CHAR_OVERLAY_BG_EN defined -> window pixels without a glyph bit become BG_COLOR.
module char_overlay #(
    parameter int          H_ORIGIN = 100,
    parameter int          V_ORIGIN = 40,
    parameter int          COLS     = 16,
    parameter int          ROWS     = 4,
    parameter int          GLYPH_W  = 12,
    parameter int          GLYPH_H  = 12,
    parameter logic [23:0] FG_COLOR = 24'hFFFF00,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input logic            clk,
    input logic            rst,
    char_overlay_if.slave  bus
);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int GCW   = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int GRW   = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    localparam int CCW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CRW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int H_END = H_ORIGIN + COLS * GLYPH_W;
    localparam int V_END = V_ORIGIN + ROWS * GLYPH_H;
    localparam int GBITS = GLYPH_W * GLYPH_H;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
    } vid_t;

    // ------------------------------------------------------------------
    // Text buffer
    // ------------------------------------------------------------------
    logic [9:0] text_q [CELLS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CELLS; i++) begin
                text_q[i] <= '0;
            end
        end else if (bus.text_we && (32'(bus.text_waddr) < 32'(CELLS))) begin
            text_q[bus.text_waddr] <= bus.text_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Window decode and glyph position counters
    // ------------------------------------------------------------------
    logic [31:0] px;
    logic [31:0] py;
    logic        h_org;
    logic        hwin;
    logic        vwin;
    logic        win;
    logic        first_de_v;
    logic        de_fall;
    logic        vwin_q;

    logic [GCW-1:0] gcol_q, gcol_d, gcol_c;
    logic [CCW-1:0] ccol_q, ccol_d, ccol_c;
    logic [GRW-1:0] grow_q, grow_d, grow_c;
    logic [CRW-1:0] crow_q, crow_d, crow_c;

    // Stage registers
    logic           s1_win_q;
    logic [AW-1:0]  s1_cell_q, s1_cell_d;
    logic [GRW-1:0] s1_grow_q;
    logic [GCW-1:0] s1_gcol_q;
    vid_t           s1_vid_q;

    logic [9:0]     s2_code_q, s2_code_d;
    logic           s2_win_q;
    logic [GRW-1:0] s2_grow_q;
    logic [GCW-1:0] s2_gcol_q;
    vid_t           s2_vid_q;

    logic           s3_win_q;
    logic [GRW-1:0] s3_grow_q;
    logic [GCW-1:0] s3_gcol_q;
    vid_t           s3_vid_q;

    logic           o_hs_q, o_vs_q, o_de_q;
    logic [23:0]    o_rgb_q, o_rgb_d;

    assign px    = 32'(bus.pix_x);
    assign py    = 32'(bus.pix_y);
    assign h_org = (px == 32'(H_ORIGIN));
    assign hwin  = (px >= 32'(H_ORIGIN)) && (px < 32'(H_END));
    assign vwin  = (py >= 32'(V_ORIGIN)) && (py < 32'(V_END));
    assign win   = hwin && vwin && bus.i_de;

    // s1_vid_q.de is the previous pixel's de, so it doubles as the edge detector.
    assign first_de_v = bus.i_de && !s1_vid_q.de && (py == 32'(V_ORIGIN));
    assign de_fall    = s1_vid_q.de && !bus.i_de && vwin_q;

    // Clears take effect on the very pixel that causes them, so the origin pixel is cell 0/row 0.
    assign gcol_c = h_org ? '0 : gcol_q;
    assign ccol_c = h_org ? '0 : ccol_q;
    assign grow_c = first_de_v ? '0 : grow_q;
    assign crow_c = first_de_v ? '0 : crow_q;

    always_comb begin
        gcol_d = gcol_c;
        ccol_d = ccol_c;
        grow_d = grow_c;
        crow_d = crow_c;
        if (win) begin
            if (gcol_c == GCW'(GLYPH_W - 1)) begin
                gcol_d = '0;
                ccol_d = (ccol_c == CCW'(COLS - 1)) ? '0 : ccol_c + CCW'(1);
            end else begin
                gcol_d = gcol_c + GCW'(1);
            end
        end
        if (de_fall) begin
            if (grow_c == GRW'(GLYPH_H - 1)) begin
                grow_d = '0;
                crow_d = (crow_c == CRW'(ROWS - 1)) ? '0 : crow_c + CRW'(1);
            end else begin
                grow_d = grow_c + GRW'(1);
            end
        end
    end

    assign s1_cell_d = AW'(32'(crow_c) * 32'(COLS) + 32'(ccol_c));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcol_q <= '0;
            ccol_q <= '0;
            grow_q <= '0;
            crow_q <= '0;
            vwin_q <= 1'b0;
        end else begin
            gcol_q <= gcol_d;
            ccol_q <= ccol_d;
            grow_q <= grow_d;
            crow_q <= crow_d;
            vwin_q <= vwin;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline: S1 position, S2 buffer read / ROM address, S3 ROM data, S4 output
    // ------------------------------------------------------------------
    // Outside the window the ROM address is left alone.
    assign s2_code_d = s1_win_q ? text_q[s1_cell_q] : s2_code_q;

    logic [7:0] bit_idx;
    logic       glyph_bit;

    assign bit_idx   = 8'(32'(GBITS - 1) - 32'(GLYPH_W) * 32'(s3_grow_q) - 32'(s3_gcol_q));
    assign glyph_bit = bus.rom_data[bit_idx];

    always_comb begin
        o_rgb_d = s3_vid_q.rgb;
        if (!s3_vid_q.de) begin
            o_rgb_d = '0;
        end else if (s3_win_q && glyph_bit) begin
            o_rgb_d = FG_COLOR;
        end
`ifdef CHAR_OVERLAY_BG_EN
        else if (s3_win_q) begin
            o_rgb_d = BG_COLOR;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_win_q  <= 1'b0;
            s1_cell_q <= '0;
            s1_grow_q <= '0;
            s1_gcol_q <= '0;
            s1_vid_q  <= '0;
            s2_code_q <= '0;
            s2_win_q  <= 1'b0;
            s2_grow_q <= '0;
            s2_gcol_q <= '0;
            s2_vid_q  <= '0;
            s3_win_q  <= 1'b0;
            s3_grow_q <= '0;
            s3_gcol_q <= '0;
            s3_vid_q  <= '0;
            o_hs_q    <= 1'b0;
            o_vs_q    <= 1'b0;
            o_de_q    <= 1'b0;
            o_rgb_q   <= '0;
        end else begin
            s1_win_q  <= win;
            s1_cell_q <= s1_cell_d;
            s1_grow_q <= grow_c;
            s1_gcol_q <= gcol_c;
            s1_vid_q  <= '{hs: bus.i_hs, vs: bus.i_vs, de: bus.i_de, rgb: bus.i_rgb};
            s2_code_q <= s2_code_d;
            s2_win_q  <= s1_win_q;
            s2_grow_q <= s1_grow_q;
            s2_gcol_q <= s1_gcol_q;
            s2_vid_q  <= s1_vid_q;
            s3_win_q  <= s2_win_q;
            s3_grow_q <= s2_grow_q;
            s3_gcol_q <= s2_gcol_q;
            s3_vid_q  <= s2_vid_q;
            o_hs_q    <= s3_vid_q.hs;
            o_vs_q    <= s3_vid_q.vs;
            o_de_q    <= s3_vid_q.de;
            o_rgb_q   <= o_rgb_d;
        end
    end

    assign bus.rom_addr = s2_code_q;
    assign bus.o_hs     = o_hs_q;
    assign bus.o_vs     = o_vs_q;
    assign bus.o_de     = o_de_q;
    assign bus.o_rgb    = o_rgb_q;

`ifndef CHAR_OVERLAY_BG_EN
    // The box colour only matters for the opaque build.
    logic unused_bg;
    assign unused_bg = ^BG_COLOR;
`endif

endmodule
